mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 20 ++
 rtl/mem_access_ctrl_timeout_cnt.sv | 45 ++++
 rtl/mem_access_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller:
// FSM state encoding, the default abort limit and a counter-width helper.
package mem_access_ctrl_pkg;

  // Default number of WAIT cycles tolerated without an ack before aborting.
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd255;

  // Controller states; DONE always lasts exactly one cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width able to represent 0..limit inclusive.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 32'd1);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// WAIT-cycle counter with synchronous clear and enable. The terminal-count
// flag is raised while the count equals LIMIT-1, i.e. during the LIMIT-th
// consecutive enabled cycle after a clear.
module mem_timeout_cnt
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = cnt_width(LIMIT);
  localparam logic [W-1:0] TC_VAL = W'(LIMIT - 32'd1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority, then increment while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller. Converts a load/store sitting in
// the EX/MEM register into a held request/ack handshake, stalls the pipeline
// while the access is outstanding, and aborts with a sticky timeout flag if
// the memory does not answer within TIMEOUT_CYCLES WAIT cycles.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        timeout_o
);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        timeout_q, timeout_d;

  logic access_s;
  logic cnt_clear_s;
  logic cnt_en_s;
  logic cnt_tc_s;
  logic stall_s;

  assign access_s    = MemRead_i | MemWrite_i;
  assign cnt_en_s    = (state_q == ST_WAIT);
  assign cnt_clear_s = (state_q != ST_WAIT);

  mem_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (cnt_clear_s),
    .en_i    (cnt_en_s),
    .tc_o    (cnt_tc_s)
  );

  // FSM next state and next values of the request/result registers.
  // An ack on the terminal-count cycle is treated as a normal completion.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (access_s) begin
          state_d = ST_WAIT;
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            rdata_d  = mem_rdata_i;
            rvalid_d = 1'b1;
          end else begin
            rvalid_d = 1'b0;
          end
        end else if (cnt_tc_s) begin
          state_d   = ST_DONE;
          req_d     = 1'b0;
          timeout_d = 1'b1;
          if (!we_q) begin
            rdata_d  = 32'h0000_0000;
            rvalid_d = 1'b1;
          end else begin
            rvalid_d = 1'b0;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Pipeline stall: held while an access is being launched or outstanding,
  // forced low during reset.
  always_comb begin
    stall_s = 1'b0;
    if (rst_i) begin
      stall_s = 1'b0;
    end else if (state_q == ST_WAIT) begin
      stall_s = 1'b1;
    end else if ((state_q == ST_IDLE) && access_s) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      rdata_q   <= 32'h0000_0000;
      rvalid_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign timeout_o     = timeout_q;
  assign stall_o       = stall_s;

endmodule
